// File: rtl/psum_bram_arbiter.sv
// Two-requester (core/host) arbiter for a single BRAM port with tagged read return.
// Optional host starvation guard enabled by defining PSUM_ARB_STARVE_GUARD_EN.
module psum_bram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int RD_LATENCY = 1,
    parameter int MAX_STREAK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_core_active,
    input  logic                  core_req,
    input  logic [NUM_BYTE-1:0]   core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdat,
    output logic                  core_gnt,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdat,
    input  logic                  host_req,
    input  logic [NUM_BYTE-1:0]   host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdat,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdat,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_idat,
    output logic [NUM_BYTE-1:0]   mem_wren,
    output logic                  mem_enb,
    output logic                  mem_rst,
    input  logic [DATA_WIDTH-1:0] mem_odat
);

    typedef enum logic [1:0] {
        IDLE,
        CORE_OWN,
        HOST_OWN
    } state_t;

    state_t                state;
    logic                  starve;
    logic                  core_first;
    logic                  core_win;
    logic                  host_win;
    logic                  core_rd0;
    logic                  host_rd0;
    logic [RD_LATENCY:1]   pipe_core;
    logic [RD_LATENCY:1]   pipe_host;
    logic [DATA_WIDTH-1:0] core_rdat_q;
    logic [DATA_WIDTH-1:0] host_rdat_q;

`ifdef PSUM_ARB_STARVE_GUARD_EN
    logic [3:0] streak;

    assign starve = host_req && (streak == 4'(MAX_STREAK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (!host_req || host_win) begin
            streak <= '0;
        end else if (core_win) begin
            streak <= streak + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    assign core_first = i_core_active && !starve;
    assign core_win   = rst && core_req && (core_first || !host_req);
    assign host_win   = rst && host_req && (!core_first || !core_req);
    assign core_gnt   = core_win;
    assign host_gnt   = host_win;
    assign mem_rst    = ~rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            unique case (1'b1)
                core_win: state <= CORE_OWN;
                host_win: state <= HOST_OWN;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= '0;
            mem_idat <= '0;
            mem_wren <= '0;
            mem_enb  <= 1'b0;
        end else if (core_win) begin
            mem_addr <= core_addr;
            mem_idat <= core_wdat;
            mem_wren <= core_we;
            mem_enb  <= 1'b1;
        end else if (host_win) begin
            mem_addr <= host_addr;
            mem_idat <= host_wdat;
            mem_wren <= host_we;
            mem_enb  <= 1'b1;
        end else begin
            mem_wren <= '0;
            mem_enb  <= 1'b0;
        end
    end

    // The owner state is aligned with the BRAM access cycle, so it tags the read.
    assign core_rd0 = (state == CORE_OWN) && mem_enb && ~|mem_wren;
    assign host_rd0 = (state == HOST_OWN) && mem_enb && ~|mem_wren;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_core <= '0;
            pipe_host <= '0;
        end else begin
            pipe_core[1] <= core_rd0;
            pipe_host[1] <= host_rd0;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                pipe_core[k] <= pipe_core[k-1];
                pipe_host[k] <= pipe_host[k-1];
            end
        end
    end

    assign core_rvalid = pipe_core[RD_LATENCY];
    assign host_rvalid = pipe_host[RD_LATENCY];
    assign core_rdat   = core_rvalid ? mem_odat : core_rdat_q;
    assign host_rdat   = host_rvalid ? mem_odat : host_rdat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rdat_q <= '0;
            host_rdat_q <= '0;
        end else begin
            if (core_rvalid) core_rdat_q <= mem_odat;
            if (host_rvalid) host_rdat_q <= mem_odat;
        end
    end

endmodule

// File: tb/tb_psum_bram_arbiter.sv
// Directed bench: one arbiter with RD_LATENCY=1, one with RD_LATENCY=3,
// each attached to a small behavioural BRAM model.
module tb_psum_bram_arbiter;

`ifdef PSUM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic i_core_active;

    logic        core_req, host_req;
    logic [3:0]  core_we, host_we;
    logic [31:0] core_addr, host_addr, core_wdat, host_wdat;
    logic        core_gnt, host_gnt, core_rvalid, host_rvalid;
    logic [31:0] core_rdat, host_rdat;
    logic [31:0] mem_addr, mem_idat, mem_odat;
    logic [3:0]  mem_wren;
    logic        mem_enb, mem_rst;

    logic        b_core_req;
    logic [31:0] b_core_addr;
    logic        b_core_gnt, b_host_gnt, b_core_rvalid, b_host_rvalid;
    logic [31:0] b_core_rdat, b_host_rdat;
    logic [31:0] b_mem_addr, b_mem_idat, b_mem_odat;
    logic [3:0]  b_mem_wren;
    logic        b_mem_enb, b_mem_rst;
    logic        zero1 = 1'b0;
    logic [3:0]  zero4 = 4'h0;
    logic [31:0] zero32 = 32'h0;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] b_p0, b_p1, b_p2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_bram_arbiter dut_a (
        .clk(clk), .rst(rst), .i_core_active(i_core_active),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdat(core_wdat), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdat(core_rdat),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdat(host_wdat), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdat(host_rdat),
        .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_wren(mem_wren),
        .mem_enb(mem_enb), .mem_rst(mem_rst), .mem_odat(mem_odat)
    );

    psum_bram_arbiter #(.RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .i_core_active(i_core_active),
        .core_req(b_core_req), .core_we(zero4), .core_addr(b_core_addr),
        .core_wdat(zero32), .core_gnt(b_core_gnt),
        .core_rvalid(b_core_rvalid), .core_rdat(b_core_rdat),
        .host_req(zero1), .host_we(zero4), .host_addr(zero32),
        .host_wdat(zero32), .host_gnt(b_host_gnt),
        .host_rvalid(b_host_rvalid), .host_rdat(b_host_rdat),
        .mem_addr(b_mem_addr), .mem_idat(b_mem_idat), .mem_wren(b_mem_wren),
        .mem_enb(b_mem_enb), .mem_rst(b_mem_rst), .mem_odat(b_mem_odat)
    );

    // BRAM A: one-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (mem_enb) begin
            if (mem_wren == 4'h0) begin
                mem_odat <= mem_a[mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_wren[b]) mem_a[mem_addr[7:0]][8*b +: 8] <= mem_idat[8*b +: 8];
            end
        end
    end

    // BRAM B: three-cycle read latency, read only
    always @(posedge clk) begin
        if (b_mem_enb && b_mem_wren == 4'h0) b_p0 <= mem_b[b_mem_addr[7:0]];
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_mem_odat = b_p2;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        core_req = 1'b1;
        host_req = 1'b1;
        #1;
        checks++;
        if (core_gnt !== 1'b0 || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got core=%b host=%b want 0/0", core_gnt, host_gnt);
        end
        checks++;
        if (mem_rst !== 1'b1 || mem_enb !== 1'b0 || mem_wren !== 4'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: got rst=%b enb=%b wren=%h addr=%h want 1/0/0/0",
                     mem_rst, mem_enb, mem_wren, mem_addr);
        end
        checks++;
        if (core_rvalid !== 1'b0 || host_rvalid !== 1'b0 ||
            core_rdat !== 32'h0 || host_rdat !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd: got cv=%b hv=%b cd=%h hd=%h want zeros",
                     core_rvalid, host_rvalid, core_rdat, host_rdat);
        end
        tick();
        tick();
        core_req = 1'b0;
        host_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rst !== 1'b0) begin
            errors++;
            $display("FAIL mem_rst_release: got %b want 0", mem_rst);
        end
        @(negedge clk);
    endtask

    task automatic test_core_read();
        i_core_active = 1'b1;
        core_req = 1'b1;
        core_we = 4'h0;
        core_addr = 32'h10;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL core_read_gnt: got core=%b host=%b want 1/0", core_gnt, host_gnt);
        end
        tick();
        core_req = 1'b0;
        checks++;
        if (mem_enb !== 1'b1 || mem_addr !== 32'h10 || mem_wren !== 4'h0 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_enb: got enb=%b addr=%h wren=%h rv=%b want 1/10/0/0",
                     mem_enb, mem_addr, mem_wren, core_rvalid);
        end
        tick();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdat !== 32'hA5A5A5A5 || host_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_data: got rv=%b d=%h hrv=%b want 1/a5a5a5a5/0",
                     core_rvalid, core_rdat, host_rvalid);
        end
        checks++;
        if (mem_enb !== 1'b0) begin
            errors++;
            $display("FAIL core_read_idle_enb: got %b want 0", mem_enb);
        end
        tick();
        checks++;
        if (core_rvalid !== 1'b0 || core_rdat !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL core_read_hold: got rv=%b d=%h want 0/a5a5a5a5", core_rvalid, core_rdat);
        end
    endtask

    task automatic test_priority(input logic act);
        logic        first_core;
        logic [31:0] first_d, second_d;
        first_core = act;
        first_d  = act ? 32'hA5A5A5A5 : 32'h11112222;
        second_d = act ? 32'h11112222 : 32'hA5A5A5A5;
        i_core_active = act;
        core_req = 1'b1;
        core_we = 4'h0;
        core_addr = 32'h10;
        host_req = 1'b1;
        host_we = 4'h0;
        host_addr = 32'h30;
        #1;
        checks++;
        if (core_gnt !== first_core || host_gnt !== !first_core) begin
            errors++;
            $display("FAIL prio%0b_first: got core=%b host=%b want %b/%b",
                     act, core_gnt, host_gnt, first_core, !first_core);
        end
        tick();
        if (first_core) core_req = 1'b0;
        else host_req = 1'b0;
        #1;
        checks++;
        if (core_gnt !== !first_core || host_gnt !== first_core) begin
            errors++;
            $display("FAIL prio%0b_second: got core=%b host=%b want %b/%b",
                     act, core_gnt, host_gnt, !first_core, first_core);
        end
        tick();
        core_req = 1'b0;
        host_req = 1'b0;
        checks++;
        if (core_rvalid !== first_core || host_rvalid !== !first_core ||
            (first_core ? core_rdat : host_rdat) !== first_d) begin
            errors++;
            $display("FAIL prio%0b_ret1: got cv=%b hv=%b cd=%h hd=%h want first data %h",
                     act, core_rvalid, host_rvalid, core_rdat, host_rdat, first_d);
        end
        tick();
        checks++;
        if (core_rvalid !== !first_core || host_rvalid !== first_core ||
            (first_core ? host_rdat : core_rdat) !== second_d) begin
            errors++;
            $display("FAIL prio%0b_ret2: got cv=%b hv=%b cd=%h hd=%h want second data %h",
                     act, core_rvalid, host_rvalid, core_rdat, host_rdat, second_d);
        end
        tick();
    endtask

    task automatic test_write_read();
        i_core_active = 1'b1;
        core_req = 1'b1;
        core_we = 4'hF;
        core_addr = 32'h20;
        core_wdat = 32'h12345678;
        #1;
        checks++;
        if (core_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wr_gnt: got %b want 1", core_gnt);
        end
        tick();
        core_req = 1'b0;
        core_we = 4'h0;
        host_req = 1'b1;
        host_we = 4'h0;
        host_addr = 32'h20;
        #1;
        checks++;
        if (host_gnt !== 1'b1 || mem_wren !== 4'hF || mem_enb !== 1'b1 ||
            mem_idat !== 32'h12345678 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL wr_mem: got hg=%b wren=%h enb=%b d=%h a=%h want 1/f/1/12345678/20",
                     host_gnt, mem_wren, mem_enb, mem_idat, mem_addr);
        end
        tick();
        host_req = 1'b0;
        checks++;
        if (mem_enb !== 1'b1 || mem_wren !== 4'h0 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_enb: got enb=%b wren=%h cv=%b want 1/0/0", mem_enb, mem_wren, core_rvalid);
        end
        tick();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdat !== 32'h12345678 || core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_back: got hv=%b hd=%h cv=%b want 1/12345678/0",
                     host_rvalid, host_rdat, core_rvalid);
        end
        tick();
    endtask

    task automatic test_streak();
        logic exp_host;
        i_core_active = 1'b1;
        core_req = 1'b1;
        core_we = 4'h0;
        core_addr = 32'h10;
        host_req = 1'b1;
        host_we = 4'h0;
        host_addr = 32'h30;
        for (int i = 0; i < 18; i++) begin
            #1;
            exp_host = GUARD && (i == 8 || i == 17);
            checks++;
            if (host_gnt !== exp_host || core_gnt !== !exp_host) begin
                errors++;
                $display("FAIL streak_%0d: got core=%b host=%b want %b/%b",
                         i, core_gnt, host_gnt, !exp_host, exp_host);
            end
            tick();
        end
        core_req = 1'b0;
        host_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_inflight();
        i_core_active = 1'b1;
        core_req = 1'b1;
        core_we = 4'h0;
        core_addr = 32'h10;
        tick();
        core_addr = 32'h30;
        rst = 1'b0;
        #1;
        checks++;
        if (core_gnt !== 1'b0 || mem_enb !== 1'b0 || mem_addr !== 32'h0 ||
            core_rdat !== 32'h0 || core_rvalid !== 1'b0 || mem_rst !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got g=%b enb=%b a=%h cd=%h cv=%b mr=%b want 0/0/0/0/0/1",
                     core_gnt, mem_enb, mem_addr, core_rdat, core_rvalid, mem_rst);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (core_gnt !== 1'b1 || mem_rst !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume: got g=%b mr=%b want 1/0", core_gnt, mem_rst);
        end
        tick();
        core_req = 1'b0;
        checks++;
        if (core_rvalid !== 1'b0 || mem_enb !== 1'b1 || mem_addr !== 32'h30) begin
            errors++;
            $display("FAIL rst_discard: got cv=%b enb=%b a=%h want 0/1/30", core_rvalid, mem_enb, mem_addr);
        end
        tick();
        checks++;
        if (core_rvalid !== 1'b1 || core_rdat !== 32'h11112222) begin
            errors++;
            $display("FAIL rst_newread: got cv=%b d=%h want 1/11112222", core_rvalid, core_rdat);
        end
        tick();
    endtask

    task automatic test_latency3();
        logic [31:0] addrs [4];
        logic [31:0] exp_d [4];
        addrs = '{32'h10, 32'h30, 32'h20, 32'h40};
        exp_d = '{32'hA5A5A5A5, 32'h11112222, 32'hDEADBEEF, 32'h33334444};
        b_core_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_core_addr = addrs[i];
            #1;
            checks++;
            if (b_core_gnt !== 1'b1 || b_core_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL lat3_gnt_%0d: got g=%b rv=%b want 1/0", i, b_core_gnt, b_core_rvalid);
            end
            tick();
        end
        b_core_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_core_rvalid !== 1'b1 || b_core_rdat !== exp_d[i] || b_host_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL lat3_data_%0d: got rv=%b d=%h hrv=%b want 1/%h/0",
                         i, b_core_rvalid, b_core_rdat, b_host_rvalid, exp_d[i]);
            end
            tick();
        end
        checks++;
        if (b_core_rvalid !== 1'b0 || b_core_rdat !== 32'h33334444) begin
            errors++;
            $display("FAIL lat3_end: got rv=%b d=%h want 0/33334444", b_core_rvalid, b_core_rdat);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[8'h10] = 32'hA5A5A5A5;
        mem_a[8'h20] = 32'hDEADBEEF;
        mem_a[8'h30] = 32'h11112222;
        mem_a[8'h40] = 32'h33334444;
        mem_b[8'h10] = 32'hA5A5A5A5;
        mem_b[8'h20] = 32'hDEADBEEF;
        mem_b[8'h30] = 32'h11112222;
        mem_b[8'h40] = 32'h33334444;
        i_core_active = 1'b1;
        core_we = 4'h0;
        host_we = 4'h0;
        core_addr = 32'h0;
        host_addr = 32'h0;
        core_wdat = 32'h0;
        host_wdat = 32'h0;
        b_core_req = 1'b0;
        b_core_addr = 32'h0;
        test_reset();
        test_core_read();
        test_priority(1'b1);
        test_priority(1'b0);
        test_write_read();
        test_streak();
        test_reset_inflight();
        test_latency3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_bram_arbiter.md
PSUM_BRAM_ARBITER -- requirements
Module: psum_bram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 32: BRAM data width.
REQ-003 Parameter NUM_BYTE, default 4: byte-write-enable width.
REQ-004 Parameter RD_LATENCY, default 1, legal 1..3: BRAM read latency, in cycles, from mem_enb to mem_odat valid.
REQ-005 Parameter MAX_STREAK, default 8, legal 1..15: consecutive core grants allowed while host waits.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 i_core_active  input  1  high: core has priority; low: host has priority.
REQ-009 core_req / host_req  input  1 each  access request, held until granted.
REQ-010 core_we / host_we  input  NUM_BYTE each  byte write enables; all-zero means read.
REQ-011 core_addr / host_addr  input  ADDR_WIDTH each  word address.
REQ-012 core_wdat / host_wdat  input  DATA_WIDTH each  write data.
REQ-013 core_gnt / host_gnt  output  1 each  request accepted this cycle.
REQ-014 core_rvalid / host_rvalid  output  1 each  read data valid.
REQ-015 core_rdat / host_rdat  output  DATA_WIDTH each  read data.
REQ-016 mem_addr, mem_idat, mem_wren, mem_enb, mem_rst  output  ADDR_WIDTH, DATA_WIDTH, NUM_BYTE, 1, 1  BRAM port.
REQ-017 mem_odat  input  DATA_WIDTH  BRAM read data.

Function
REQ-018 Grant combinational, same cycle as request; at most one of core_gnt/host_gnt high per cycle.
REQ-019 Priority: i_core_active=1 -> core first; i_core_active=0 -> host first; a lone requester is always granted.
REQ-020 FSM states IDLE, CORE_OWN, HOST_OWN record last granted requester; no grant -> IDLE; grant -> owner state.
REQ-021 Granted access drives mem_addr/mem_idat/mem_wren registered, mem_enb=1 one cycle after grant (T+1); no grant -> mem_enb=0, mem_wren=0.
REQ-022 Read accesses push owner tag into RD_LATENCY-deep tag pipeline; owner rvalid high exactly at T+1+RD_LATENCY for one cycle; rdat = mem_odat that cycle.
REQ-023 Non-owner rvalid stays 0; non-owner rdat holds its last value.
REQ-024 Writes produce no rvalid; back-to-back accesses sustain one access per cycle with no bubble.
REQ-025 Mid-operation i_core_active toggle affects only arbitration in that cycle; in-flight reads complete to their original owner.
REQ-026 mem_rst held 0 at all times outside reset.

Reset
REQ-027 rst low asynchronously clears: FSM to IDLE, tag pipeline, streak counter, mem_addr/mem_idat/mem_wren/mem_enb to 0, all rvalid/rdat to 0; mem_rst=1 while rst low.
REQ-028 Grants forced 0 while rst low; in-flight reads discarded, no rvalid after release.
REQ-029 First grant possible in first cycle after rst deasserts.

Configuration
REQ-030 Macro PSUM_ARB_STARVE_GUARD_EN defined: 4-bit streak counter counts consecutive core grants while host_req high; when counter = MAX_STREAK and host_req high, host granted over core and counter cleared; counter cleared on any host grant or host_req low.
REQ-031 Macro not defined: strict priority per REQ-019, no counter logic; host may starve indefinitely.

Verification
REQ-032 Core read only, addr 0x10, mem_odat=0xA5A5A5A5, RD_LATENCY=1 -> core_gnt at T, mem_enb at T+1, core_rvalid with 0xA5A5A5A5 at T+2, host_rvalid 0.
REQ-033 Both request reads, i_core_active=1 -> core_gnt first; i_core_active=0 -> host_gnt first; data returns to correct owner.
REQ-034 Guard enabled, MAX_STREAK=8, core_req and host_req held, i_core_active=1 -> 8 core grants, then 1 host grant, then core resumes; guard disabled -> host never granted.
REQ-035 Alternating core write (we=4'hF, 0x20, 0x12345678) then host read 0x20 back-to-back -> mem_wren=4'hF cycle T+1, host read enb T+2, host_rvalid T+3, no rvalid to core.
REQ-036 rst low for one cycle while read in flight -> all outputs 0 immediately, no rvalid after release, grant resumes next cycle.
REQ-037 RD_LATENCY=3, four consecutive core reads -> four consecutive core_rvalid pulses starting T+4, data in issue order.
